// File: rtl/alu_mul_seq_if.sv
// Operand/result bundle for the sequential shift-add multiplier.
interface alu_mul_seq_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  data_valid;
  logic [3:0]            opcode;
  logic [DATA_WIDTH-1:0] data_a;
  logic [DATA_WIDTH-1:0] data_b;
  logic                  busy;
  logic [DATA_WIDTH-1:0] result;
  logic                  result_valid;
  logic [3:0]            result_flags;

  modport master (
    output data_valid, opcode, data_a, data_b,
    input  busy, result, result_valid, result_flags
  );

  modport slave (
    input  data_valid, opcode, data_a, data_b,
    output busy, result, result_valid, result_flags
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Sequential shift-add multiplier (MUL low half / MULH high half, unsigned), one multiplier bit per clock.
// Optional early termination when remaining multiplier bits are zero: define ALU_MUL_EARLY_EXIT_EN.
module alu_mul_seq #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  alu_mul_seq_if.slave bus
);
  localparam int unsigned W     = DATA_WIDTH;
  localparam int unsigned W2    = 2 * DATA_WIDTH;
  localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
  localparam logic [3:0]  OP_MUL  = 4'h5;
  localparam logic [3:0]  OP_MULH = 4'h8;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [W2-1:0]     mcand_q, mcand_d;
  logic [W-1:0]      mplier_q, mplier_d;
  logic [W2-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        op_q, op_d;
  logic              busy_q, busy_d;
  logic [W-1:0]      result_q, result_d;
  logic [3:0]        flags_q, flags_d;
  logic              valid_q, valid_d;

  logic [W2-1:0]     sum_c;
  logic [W-1:0]      sel_c;
  logic              last_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state, datapath step and completion outputs.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    busy_d   = busy_q;
    result_d = result_q;
    flags_d  = flags_q;
    valid_d  = 1'b0;

    sum_c = acc_q + (mplier_q[0] ? mcand_q : {W2{1'b0}});
`ifdef ALU_MUL_EARLY_EXIT_EN
    last_c = (mplier_q[W-1:1] == '0) || (cnt_q == CNT_W'(W - 1));
`else
    last_c = (cnt_q == CNT_W'(W - 1));
`endif
    case (op_q)
      OP_MUL:  sel_c = sum_c[W-1:0];
      OP_MULH: sel_c = sum_c[W2-1:W];
      default: sel_c = '0;
    endcase

    case (state_q)
      IDLE: begin
        if (bus.data_valid) begin
          state_d  = BUSY;
          busy_d   = 1'b1;
          mcand_d  = {{W{1'b0}}, bus.data_a};
          mplier_d = bus.data_b;
          acc_d    = '0;
          cnt_d    = '0;
          op_d     = bus.opcode;
        end
      end
      BUSY: begin
        acc_d    = sum_c;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_c) begin
          state_d  = IDLE;
          busy_d   = 1'b0;
          valid_d  = 1'b1;
          result_d = sel_c;
          flags_d  = {1'b0,
                      (op_q == OP_MUL) && (sum_c[W2-1:W] != '0),
                      sel_c[W-1],
                      sel_c == '0};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
      busy_q   <= 1'b0;
      result_q <= '0;
      flags_q  <= 4'b0001;
      valid_q  <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      busy_q   <= busy_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.busy         = busy_q;
  assign bus.result       = result_q;
  assign bus.result_valid = valid_q;
  assign bus.result_flags = flags_q;
endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed self-checking bench for alu_mul_seq (DATA_WIDTH=8); latency expectations follow ALU_MUL_EARLY_EXIT_EN.
module tb_alu_mul_seq;
  localparam logic [3:0] OP_MUL  = 4'h5;
  localparam logic [3:0] OP_MULH = 4'h8;

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_err    = 0;
  logic [7:0] prev_r;
  logic [3:0] prev_f;

  alu_mul_seq_if #(.DATA_WIDTH(8)) bus ();
  alu_mul_seq #(.DATA_WIDTH(8)) dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int exp_lat(input logic [7:0] b);
`ifdef ALU_MUL_EARLY_EXIT_EN
    int l = 1;
    for (int i = 0; i < 8; i++) if (b[i]) l = i + 1;
    return l;
`else
    return 8;
`endif
  endfunction

  // Called at edge+1; accepts at the next edge and returns at completion edge+1.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] exp_r, input logic [3:0] exp_f,
                        input int inject_at);
    int n = 0;
    int hold_err = 0;
    int busy_err = 0;
    bus.data_valid = 1'b1; bus.opcode = op; bus.data_a = a; bus.data_b = b;
    @(posedge clk); #1;
    bus.data_valid = 1'b0; bus.data_a = 8'hA5; bus.data_b = 8'h5A; bus.opcode = 4'hF;
    check({tag, "_busy_e0"}, 32'(bus.busy), 32'd1);
    check({tag, "_rv_low_e0"}, 32'(bus.result_valid), 32'd0);
    while (!bus.result_valid && n < 40) begin
      if (inject_at != 0 && n == inject_at - 1) begin
        bus.data_valid = 1'b1; bus.opcode = OP_MUL; bus.data_a = 8'h02; bus.data_b = 8'h02;
      end else if (inject_at != 0 && n == inject_at) begin
        bus.data_valid = 1'b0;
      end
      @(posedge clk); #1;
      n++;
      if (!bus.result_valid) begin
        if (!bus.busy) busy_err++;
        if (bus.result !== prev_r || bus.result_flags !== prev_f) hold_err++;
      end
    end
    bus.data_valid = 1'b0;
    check({tag, "_latency"}, 32'(n), 32'(exp_lat(b)));
    check({tag, "_busy_during"}, 32'(busy_err), 32'd0);
    check({tag, "_hold"}, 32'(hold_err), 32'd0);
    check({tag, "_result"}, 32'(bus.result), 32'(exp_r));
    check({tag, "_flags"}, 32'(bus.result_flags), 32'(exp_f));
    check({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
    prev_r = exp_r;
    prev_f = exp_f;
  endtask

  initial begin
    int extra;
    int busy_hi;
    reset_n = 1'b0;
    bus.data_valid = 1'b0; bus.opcode = 4'h0; bus.data_a = 8'h00; bus.data_b = 8'h00;
    prev_r = 8'h00; prev_f = 4'b0001;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_rv", 32'(bus.result_valid), 32'd0);
    check("rst_flags", 32'(bus.result_flags), 32'b0001);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    run_op("mul_7x6", OP_MUL, 8'h07, 8'h06, 8'h2A, 4'b0000, 0);
    @(posedge clk); #1;
    check("mul_7x6_rv_one_cycle", 32'(bus.result_valid), 32'd0);

    run_op("mul_ffxff", OP_MUL, 8'hFF, 8'hFF, 8'h01, 4'b0100, 0);
    run_op("mulh_ffxff", OP_MULH, 8'hFF, 8'hFF, 8'hFE, 4'b0010, 0);
    run_op("mul_00x5a", OP_MUL, 8'h00, 8'h5A, 8'h00, 4'b0001, 0);
    run_op("mul_5ax00", OP_MUL, 8'h5A, 8'h00, 8'h00, 4'b0001, 0);
    run_op("mul_80x02", OP_MUL, 8'h80, 8'h02, 8'h00, 4'b0101, 0);
    run_op("mulh_40x08", OP_MULH, 8'h40, 8'h08, 8'h02, 4'b0000, 0);
    run_op("mulh_7x6", OP_MULH, 8'h07, 8'h06, 8'h00, 4'b0001, 0);
    run_op("bad_op", 4'h3, 8'h05, 8'h05, 8'h00, 4'b0001, 0);

    // Back-to-back: second strobe driven in the result_valid cycle.
    run_op("mul_03x10", OP_MUL, 8'h03, 8'h10, 8'h30, 4'b0000, 0);
    run_op("b2b_0bx0d", OP_MUL, 8'h0B, 8'h0D, 8'h8F, 4'b0010, 0);
    @(posedge clk); #1;

    // Strobe while busy must be ignored.
    run_op("mul_9x9_inj", OP_MUL, 8'h09, 8'h09, 8'h51, 4'b0000, 3);
    extra = 0; busy_hi = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus.result_valid) extra++;
      if (bus.busy) busy_hi++;
    end
    check("inj_single_rv", 32'(extra), 32'd0);
    check("inj_no_busy_ext", 32'(busy_hi), 32'd0);
    check("inj_result_kept", 32'(bus.result), 32'h51);

    // Asynchronous reset mid-operation.
    bus.data_valid = 1'b1; bus.opcode = OP_MUL; bus.data_a = 8'h12; bus.data_b = 8'h34;
    @(posedge clk); #1;
    bus.data_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    #3 reset_n = 1'b0;
    #1;
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_result", 32'(bus.result), 32'd0);
    check("arst_rv", 32'(bus.result_valid), 32'd0);
    check("arst_flags", 32'(bus.result_flags), 32'b0001);
    extra = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.result_valid) extra++;
    end
    @(negedge clk) reset_n = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.result_valid) extra++;
    end
    check("arst_no_rv", 32'(extra), 32'd0);
    prev_r = 8'h00; prev_f = 4'b0001;
    run_op("mul_3x5", OP_MUL, 8'h03, 8'h05, 8'h0F, 4'b0000, 0);
    @(posedge clk); #1;
    check("mul_3x5_rv_one_cycle", 32'(bus.result_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
